mem_word_master: RTL

MEM_WORD_MASTER -- requirements
Module: mem_word_master

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_word_master.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: size and state encodings plus default widths shared by the
// byte-serial CPU-to-memory master.
package mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 13;
  localparam int CPU_WIDTH          = 32;
  localparam int LANE_WIDTH         = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // The reserved size code behaves as a full word.
  function automatic logic [2:0] size_to_bytes(input size_e size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_master.sv
// mem_word_master: splits 8/16/32-bit CPU accesses into single-byte requests on
// a one-outstanding memory port. Define MEM_WORD_MASTER_TIMEOUT_EN to bound each WAIT.
module mem_word_master
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [1:0]            i_cpu_size,
  input  logic [CPU_WIDTH-1:0]  i_cpu_addr,
  input  logic [CPU_WIDTH-1:0]  i_cpu_wdata,
  output logic [CPU_WIDTH-1:0]  o_cpu_rdata,
  output logic                  o_cpu_done,
  output logic                  o_cpu_err,
  output logic                  o_busy,
  output logic                  o_mem_request,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_data_DV
);

`ifdef MEM_WORD_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int             TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic                    accept, byte_done, timeout_hit;
  logic                    last_byte, timeout_expired;

  logic                    we_q;
  size_e                   size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CPU_WIDTH-1:0]    wdata_q;
  logic [CPU_WIDTH-1:0]    rdata_q;
  logic [2:0]              idx_q;
  logic                    err_q;
  logic [TMO_W-1:0]        tmo_q;

  logic [1:0]              lane;
  logic [LANE_WIDTH-1:0]   wr_lane, rd_lane;
  logic                    unused_addr_bits;

  // Addresses above the memory window are deliberately dropped.
  assign unused_addr_bits = ^i_cpu_addr[CPU_WIDTH-1:ADDR_WIDTH];

  assign lane            = idx_q[1:0];
  assign last_byte       = (idx_q + 3'd1) == size_to_bytes(size_q);
  assign wr_lane         = wdata_q[{lane, 3'b000} +: LANE_WIDTH];
  assign rd_lane         = LANE_WIDTH'(i_mem_data);
  assign timeout_expired = TIMEOUT_EN && (tmo_q == TMO_LIMIT);

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every value driven here gets a default first so no path can infer a latch.
    state_d       = state_q;
    accept        = 1'b0;
    byte_done     = 1'b0;
    timeout_hit   = 1'b0;
    o_busy        = (state_q != ST_IDLE);
    o_mem_request = 1'b0;
    o_cpu_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cpu_req) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_mem_request = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_mem_data_DV) begin
          byte_done = 1'b1;
          state_d   = last_byte ? ST_DONE : ST_ISSUE;
        end else if (timeout_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        o_cpu_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= i_cpu_we;
        size_q  <= size_e'(i_cpu_size);
        addr_q  <= i_cpu_addr[ADDR_WIDTH-1:0];
        wdata_q <= i_cpu_wdata;
        rdata_q <= '0;
        idx_q   <= '0;
        err_q   <= 1'b0;
      end
      // Bytes never returned stay zero, so short reads are zero-extended.
      if (byte_done) begin
        if (!we_q) rdata_q[{lane, 3'b000} +: LANE_WIDTH] <= rd_lane;
        idx_q <= idx_q + 3'd1;
      end
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  // Per-byte WAIT counter restarts every time a new byte is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_WAIT) tmo_q <= '0;
    else                             tmo_q <= tmo_q + TMO_W'(1);
  end

  assign o_cpu_rdata   = rdata_q;
  assign o_cpu_err     = TIMEOUT_EN & err_q;
  assign o_mem_write   = we_q;
  assign o_mem_address = addr_q + ADDR_WIDTH'(idx_q);
  assign o_mem_data    = DATA_WIDTH'(wr_lane);

endmodule
